layer_scheduler: RTL

//  Game-flow controller for the block field. Seeds the field at start, generates the next layer
//  (map/type/bonus) with an LFSR, turns button presses into one-cycle jump_left/jump_right pulses,

---
 rtl/layer_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/layer_scheduler.sv
// ---------------------------------------------------------------------------
// layer_scheduler
//   Game-flow controller for the block field. It seeds the field at game
//   start, generates the next layer (map/type/bonus) from a Galois LFSR,
//   turns debounced button presses into one-cycle jump pulses paced
//   against the shift animation, and keeps a saturating jump score.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active low
//   module_en    game enable; low returns the controller to IDLE
//   one_ms_tick  1-cycle pulse every millisecond (animation pacing)
//   btn_left     1-cycle debounced press
//   btn_right    1-cycle debounced press
//   jump_fail    registered fail flag from the block field
//   bonus        registered bonus flag from the block field
//   jump_left    1-cycle jump pulse
//   jump_right   1-cycle jump pulse
//   load_layer   1-cycle layer-load pulse
//   layer_map    [0:6] next layer solid-block map
//   block_type   [0:6] next layer type (1 = stable, 0 = breaking)
//   bonus_map    [0:6] next layer bonus map
//   busy         high while filling, jumping or animating
//   game_over    high once a jump has failed
//   score        16-bit saturating score
//
// The layer buses are [0:6]; a 7-bit LFSR slice is assigned MSB-first, so
// lfsr[15] lands on layer_map[0]. The forced solid column g is the bus
// index g (layer_map[g] is always 1).
// ---------------------------------------------------------------------------
module layer_scheduler #(
  parameter int          NUM_LAYERS = 5,
  parameter int          FILL_GAP   = 4,
  parameter int          SHIFT_MS   = 200,
  parameter int          BONUS_PTS  = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        module_en,
  input  logic        one_ms_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        jump_fail,
  input  logic        bonus,
  output logic        jump_left,
  output logic        jump_right,
  output logic        load_layer,
  output logic [0:6]  layer_map,
  output logic [0:6]  block_type,
  output logic [0:6]  bonus_map,
  output logic        busy,
  output logic        game_over,
  output logic [15:0] score
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_JUMP  = 3'd3;
  localparam logic [2:0] S_ANIM  = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam int GAP_W   = $clog2(FILL_GAP);
  localparam int LAYER_W = $clog2(NUM_LAYERS + 1);
  localparam int MS_W    = $clog2(SHIFT_MS + 1);

  logic [2:0]         state_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [LAYER_W-1:0] layer_cnt_reg;
  logic [MS_W-1:0]    ms_cnt_reg;
  logic [15:0]        lfsr_reg;
  logic [15:0]        score_reg;
  logic               pend_valid_reg;
  logic               pend_right_reg;
  logic               dir_right_reg;

  logic        idle;
  logic        press;
  logic        advance;
  logic [15:0] lfsr_next;
  logic [16:0] score_sum;
  logic [15:0] score_sat;
  logic [2:0]  g;
  logic [0:6]  oh;
  logic [0:6]  raw_map;
  logic [0:6]  raw_keep;
  logic [0:6]  lm;
  logic [0:6]  bt;
  logic [0:6]  bm;

  // Simultaneous left+right is treated as no press at all.
  assign press = btn_left ^ btn_right;
  assign idle  = (state_reg == S_IDLE);

  assign load_layer = (state_reg == S_FILL) && (gap_cnt_reg == '0);
  assign jump_left  = (state_reg == S_JUMP) && !dir_right_reg;
  assign jump_right = (state_reg == S_JUMP) &&  dir_right_reg;
  assign busy       = (state_reg == S_FILL) || (state_reg == S_JUMP) ||
                      (state_reg == S_ANIM);
  assign game_over  = (state_reg == S_OVER);
  assign score      = score_reg;

  // The LFSR steps in the same cycle as the pulse, so the bus value shown
  // during the pulse is the one the block field latches.
  assign advance   = load_layer || (state_reg == S_JUMP);
  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

  // Column g is always solid and stable so every layer has a landing spot.
  assign g        = (lfsr_reg[2:0] == 3'd7) ? 3'd3 : lfsr_reg[2:0];
  assign oh       = 7'b1000000 >> g;
  assign raw_map  = lfsr_reg[15:9];
  assign raw_keep = lfsr_reg[8:2];
  assign lm       = raw_map | oh;
  assign bt       = (lm & ~raw_keep) | oh;
  assign bm       = lm & bt & {7{lfsr_reg[0] & lfsr_reg[1]}} & ~oh;

  assign layer_map  = idle ? 7'b0 : lm;
  assign block_type = idle ? 7'b0 : bt;
  assign bonus_map  = idle ? 7'b0 : bm;

  assign score_sum = {1'b0, score_reg} + 17'd1 + (bonus ? 17'(BONUS_PTS) : 17'd0);
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_ff @(posedge clk) begin
    if (!rst || !module_en) begin
      state_reg      <= S_IDLE;
      gap_cnt_reg    <= '0;
      layer_cnt_reg  <= '0;
      ms_cnt_reg     <= '0;
      lfsr_reg       <= LFSR_SEED;
      score_reg      <= '0;
      pend_valid_reg <= 1'b0;
      pend_right_reg <= 1'b0;
      dir_right_reg  <= 1'b0;
    end else begin
      if (advance) begin
        lfsr_reg <= lfsr_next;
      end
      case (state_reg)
        S_IDLE: begin
          state_reg     <= S_FILL;
          gap_cnt_reg   <= '0;
          layer_cnt_reg <= '0;
        end
        S_FILL: begin
          // The trailing gap after the last load is part of FILL.
          if (gap_cnt_reg == GAP_W'(FILL_GAP - 1)) begin
            gap_cnt_reg <= '0;
            if (layer_cnt_reg == LAYER_W'(NUM_LAYERS - 1)) begin
              state_reg <= S_READY;
            end else begin
              layer_cnt_reg <= layer_cnt_reg + 1'b1;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        S_READY: begin
          // A buffered press wins; a same-cycle press is dropped.
          if (pend_valid_reg) begin
            dir_right_reg <= pend_right_reg;
            state_reg     <= S_JUMP;
          end else if (press) begin
            dir_right_reg <= btn_right;
            state_reg     <= S_JUMP;
          end
        end
        S_JUMP: begin
          // Clearing the buffer and capturing a press in this cycle combine
          // into a plain load of the current press.
          pend_valid_reg <= press;
          pend_right_reg <= btn_right;
          ms_cnt_reg     <= '0;
          state_reg      <= S_ANIM;
        end
        S_ANIM: begin
          if (press) begin
            pend_valid_reg <= 1'b1;
            pend_right_reg <= btn_right;
          end
          if (one_ms_tick) begin
            if (ms_cnt_reg == MS_W'(SHIFT_MS - 1)) begin
              if (jump_fail) begin
                state_reg      <= S_OVER;
                pend_valid_reg <= 1'b0;
              end else begin
                score_reg <= score_sat;
                state_reg <= S_READY;
              end
            end else begin
              ms_cnt_reg <= ms_cnt_reg + 1'b1;
            end
          end
        end
        S_OVER: begin
          state_reg <= S_OVER;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
